// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared widths, FSM encoding and ALU op codes
package alu_arbiter_pkg;
    localparam int WIDTH_DEF = 32;
    localparam int OP_SZ_DEF = 4;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_NAND,
        OP_XNOR, OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_GT, OP_EQ, OP_PASSB
    } alu_op_t;
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: two requester channels plus the shared response channel
interface alu_arbiter_if #(parameter int WIDTH = 32, parameter int OP_SZ = 4);
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b, rsp_data;
    logic [OP_SZ-1:0] req0_sel, req1_sel;
    logic             rsp_valid, rsp_ready, rsp_id, busy;
    modport master (
        output req0_valid, req0_a, req0_b, req0_sel, req1_valid, req1_a, req1_b, req1_sel, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, busy
    );
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sel, req1_valid, req1_a, req1_b, req1_sel, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, busy
    );
endinterface

// File: rtl/alu_arbiter_alu.sv
// alu: combinational 16-operation ALU shared by the arbiter
module alu
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OP_SZ = OP_SZ_DEF
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [OP_SZ-1:0] ALU_Sel,
    output logic [WIDTH-1:0] ALU_Out
);
    always_comb begin
        ALU_Out = '0;
        case (ALU_Sel)
            OP_ADD:   ALU_Out = A + B;
            OP_SUB:   ALU_Out = A - B;
            OP_MUL:   ALU_Out = A * B;
            OP_AND:   ALU_Out = A & B;
            OP_OR:    ALU_Out = A | B;
            OP_XOR:   ALU_Out = A ^ B;
            OP_NOR:   ALU_Out = ~(A | B);
            OP_NAND:  ALU_Out = ~(A & B);
            OP_XNOR:  ALU_Out = ~(A ^ B);
            OP_SHL:   ALU_Out = A << 1;
            OP_SHR:   ALU_Out = A >> 1;
            OP_ROL:   ALU_Out = {A[WIDTH-2:0], A[WIDTH-1]};
            OP_ROR:   ALU_Out = {A[0], A[WIDTH-1:1]};
            OP_GT:    ALU_Out = {{(WIDTH-1){1'b0}}, A > B};
            OP_EQ:    ALU_Out = {{(WIDTH-1){1'b0}}, A == B};
            OP_PASSB: ALU_Out = B;
            default:  ALU_Out = '0;
        endcase
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two requesters via IDLE/EXEC/RESP
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OP_SZ = OP_SZ_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_data, w_alu_out;
    logic [OP_SZ-1:0] r_sel;
    logic             r_id, r_rsp_id, r_last, w_gnt1, w_any;

    assign w_any  = bus.req0_valid | bus.req1_valid;
    // requester 1 wins when alone, or on a tie when requester 0 was served last
    assign w_gnt1 = bus.req1_valid & (~bus.req0_valid | ~r_last);
    assign bus.req0_ready = rst_n & (r_state == IDLE) & bus.req0_valid & ~w_gnt1;
    assign bus.req1_ready = rst_n & (r_state == IDLE) & w_gnt1;
    assign bus.rsp_valid  = r_state == RESP;
    assign bus.busy       = r_state != IDLE;
    assign bus.rsp_data   = r_data;
    assign bus.rsp_id     = r_rsp_id;

    always_comb begin
        w_next = IDLE;
        w_next = (r_state == IDLE && w_any) ? EXEC :
                 (r_state == EXEC) ? RESP :
                 (r_state == RESP && !bus.rsp_ready) ? RESP : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sel    <= '0;
            r_id     <= 1'b0;
            r_data   <= '0;
            r_rsp_id <= 1'b0;
            r_last   <= 1'b1;
        end else begin
            if (r_state == IDLE && w_any) begin
                r_a   <= w_gnt1 ? bus.req1_a : bus.req0_a;
                r_b   <= w_gnt1 ? bus.req1_b : bus.req0_b;
                r_sel <= w_gnt1 ? bus.req1_sel : bus.req0_sel;
                r_id  <= w_gnt1;
            end
            if (r_state == EXEC) begin
                r_data   <= w_alu_out;
                r_rsp_id <= r_id;
            end
            if (r_state == RESP && bus.rsp_ready) r_last <= r_rsp_id;
        end
    end

    alu #(.WIDTH(WIDTH), .OP_SZ(OP_SZ)) u_alu (
        .A(r_a), .B(r_b), .ALU_Sel(r_sel), .ALU_Out(w_alu_out)
    );
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width.
REQ-002 Parameter OP_SZ, default 4, ALU operation-select width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0_valid  input  1  requester 0 has an operation pending.
REQ-006 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-007 req0_a, req0_b  input  WIDTH  requester 0 operands A, B.
REQ-008 req0_sel  input  OP_SZ  requester 0 ALU select.
REQ-009 req1_valid, req1_ready, req1_a, req1_b, req1_sel  same directions, widths and meanings as REQ-005..008, for requester 1.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  consumer accepts result.
REQ-012 rsp_data  output  WIDTH  ALU result.
REQ-013 rsp_id  output  1  requester index that issued the result.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The block SHALL share one alu instance (ports A, B, ALU_Sel, ALU_Out) between two requesters through a three-state FSM: IDLE, EXEC, RESP.
REQ-016 IDLE: if neither valid is high, stay in IDLE; otherwise grant one requester, pulse its ready for exactly that cycle, latch its a/b/sel and index, and go to EXEC.
REQ-017 Grant SHALL be round-robin: if only one valid is high, grant it; if both are high, grant the requester not granted last; after reset the last-granted pointer is 1, so requester 0 wins the first tie.
REQ-018 At most one ready SHALL be high per cycle, and ready SHALL be high only in IDLE while the matching valid is high.
REQ-019 EXEC: drive the latched operands and select into the alu, capture ALU_Out into rsp_data and the latched index into rsp_id, go to RESP; EXEC always lasts one cycle.
REQ-020 RESP: hold rsp_valid high with rsp_data and rsp_id stable until a cycle with rsp_ready high, then update the last-granted pointer to rsp_id and go to IDLE.
REQ-021 Latency: a ready pulse in cycle N SHALL give rsp_valid high from cycle N+2; with rsp_ready held high, a new grant SHALL be possible in cycle N+3, giving one operation per 3 cycles at best.
REQ-022 Requester operand changes after acceptance SHALL NOT affect the result in flight.
REQ-023 rsp_data SHALL equal ALU_Out for the latched operands at full WIDTH, with no truncation or extension; all OP_SZ select codes pass through unmodified.
REQ-024 rsp_ready high outside RESP SHALL be ignored; valid deasserted before grant SHALL be ignored and lose no state.

Reset
REQ-025 rst_n low SHALL asynchronously force: state IDLE, req0_ready=0, req1_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, last-granted pointer=1.
REQ-026 Reset in EXEC or RESP SHALL discard the in-flight operation with no response produced; after rst_n rises the first clock edge evaluates IDLE normally.

Structure
REQ-027 A shared package SHALL hold WIDTH and OP_SZ defaults and the FSM state encoding (IDLE, EXEC, RESP), and shall be reusable by the alu and the testbench.
REQ-028 The existing alu SHALL be the single instantiated sub-module; arbitration, operand latching and the FSM are in alu_arbiter.

Verification
REQ-029 Single request: req0 A=4, B=3, sel=0 valid for one operation -> req0_ready pulses at cycle N, rsp_valid at N+2, rsp_data = direct alu(4,3,0), rsp_id=0.
REQ-030 Tie: both valid from reset, req0 A=4,B=3,sel=1 and req1 A=8,B=2,sel=2, rsp_ready=1 -> grants alternate 0,1,0,1 with every ready pulse 3 cycles after the previous one, each result matching its own operands.
REQ-031 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stay stable, no ready pulse occurs, and IDLE follows the cycle rsp_ready=1.
REQ-032 Operand change: after req1 is accepted with A=4,B=3, change req1_a to 0xFFFFFFFF during EXEC -> the result still matches A=4,B=3.
REQ-033 Reset mid-operation: drop rst_n during EXEC -> all outputs 0 immediately, with no rsp_valid after release; the next tie grants requester 0.
REQ-034 Sweep: sel 0..15 with A=4,B=3 through requester 0 -> all 16 results equal the direct alu instance output.
